// File: rtl/loop_pkg.sv
// Shared definitions for the loop lock controller: lock FSM states and default sizing.
package loop_pkg;

  typedef enum logic [1:0] {
    IDLE,
    TRAIN,
    LOCKED
  } lock_state_e;

  localparam int unsigned DEF_ENTRIES  = 4;
  localparam int unsigned DEF_PC_W     = 31;
  localparam int unsigned DEF_CNT_W    = 4;
  localparam int unsigned DEF_MAX_BODY = 0;

endpackage

// File: rtl/loop_stack.sv
// Circular loop stack with head pointer and explicit count; also exposes the
// post-update top entry so the controller can qualify in the same cycle.
module loop_stack #(
  parameter int unsigned ENTRIES = 4,
  parameter int unsigned PC_W    = 31,
  parameter int unsigned CNT_W   = 4,
  localparam int unsigned PTR_W  = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic              replace,
  input  logic              incr,
  input  logic [PC_W-1:0]   in_first,
  input  logic [PC_W-1:0]   in_last,
  output logic [PTR_W:0]    count,
  output logic [PC_W-1:0]   top_first,
  output logic [PC_W-1:0]   top_last,
  output logic [PTR_W:0]    nxt_count,
  output logic [PC_W-1:0]   nxt_first,
  output logic [PC_W-1:0]   nxt_last,
  output logic [CNT_W-1:0]  nxt_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]  first;
    logic [PC_W-1:0]  last;
    logic [CNT_W-1:0] cnt;
  } entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(ENTRIES);

  entry_t           mem [ENTRIES];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] nxt_head;
  entry_t           top_e;
  entry_t           new_e;
  entry_t           nxt_top;
  entry_t           wr_data;
  logic             wr_en;

  assign top_e     = mem[head];
  assign top_first = top_e.first;
  assign top_last  = top_e.last;
  assign new_e     = '{first: in_first, last: in_last, cnt: CNT_W'(1)};

  always_comb begin
    nxt_head  = head;
    nxt_count = count;
    nxt_top   = top_e;
    wr_en     = 1'b0;
    wr_data   = top_e;
    if (clr) begin
      nxt_count = '0;
    end else if (replace) begin
      wr_en   = 1'b1;
      wr_data = new_e;
      nxt_top = new_e;
    end else if (push) begin
      // When full, advancing head lands on the oldest slot, overwriting it.
      nxt_head  = head + PTR_W'(1);
      nxt_count = (count == FULL) ? count : count + (PTR_W+1)'(1);
      wr_en     = 1'b1;
      wr_data   = new_e;
      nxt_top   = new_e;
    end else if (pop) begin
      nxt_head  = head - PTR_W'(1);
      nxt_count = count - (PTR_W+1)'(1);
      nxt_top   = mem[head - PTR_W'(1)];
    end else if (incr) begin
      wr_en   = 1'b1;
      wr_data = top_e;
      if (!(&top_e.cnt)) wr_data.cnt = top_e.cnt + CNT_W'(1);
      nxt_top = wr_data;
    end
  end

  assign nxt_first = nxt_top.first;
  assign nxt_last  = nxt_top.last;
  assign nxt_cnt   = nxt_top.cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) mem[i].cnt <= '0;
    end else begin
      head  <= nxt_head;
      count <= nxt_count;
      if (wr_en) mem[nxt_head] <= wr_data;
    end
  end

endmodule

// File: rtl/loop_lock_ctrl.sv
// Decode-stage nested loop detector that requests an I-cache lock once the
// innermost loop has iterated enough and its body fits the size limit.
module loop_lock_ctrl
  import loop_pkg::*;
#(
  parameter int unsigned ENTRIES  = DEF_ENTRIES,
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned MAX_BODY = DEF_MAX_BODY,
  localparam int unsigned PTR_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_valid,
  input  logic             is_call,
  input  logic             flush,
  input  logic             dec_takenbr,
  input  logic [PC_W-1:0]  dec_takenbr_target,
  input  logic [PC_W-1:0]  last_pc,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic             lock_cache,
  output logic             lock_start,
  output logic             lock_end,
  output logic [PTR_W:0]   depth
);

  localparam logic [PC_W-1:0] BODY_LIM = PC_W'(MAX_BODY);

  lock_state_e      state;
  lock_state_e      nxt_state;
  logic [PC_W-1:0]  top_first;
  logic [PC_W-1:0]  top_last;
  logic [PTR_W:0]   nxt_count;
  logic [PC_W-1:0]  nxt_first;
  logic [PC_W-1:0]  nxt_last;
  logic [CNT_W-1:0] nxt_cnt;
  logic [CNT_W-1:0] thr_eff;
  logic             clr, bwd, have, hit, new_loop, leave;
  logic             push, pop, replace, incr;
  logic             body_ok, qual;

  assign clr      = is_call | flush;
  assign bwd      = dec_takenbr & ~is_call & (dec_takenbr_target < last_pc);
  assign have     = depth != '0;
  assign hit      = bwd & have & (dec_takenbr_target == top_first) & (last_pc == top_last);
  assign new_loop = bwd & ~hit;
  assign leave    = inst_valid & have & ~hit & ((last_pc < top_first) | (last_pc > top_last));

  assign push     = ~clr & new_loop & ~leave;
  assign replace  = ~clr & new_loop & leave;
  assign pop      = ~clr & leave & ~new_loop;
  assign incr     = ~clr & hit;

  loop_stack #(
    .ENTRIES (ENTRIES),
    .PC_W    (PC_W),
    .CNT_W   (CNT_W)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .push      (push),
    .pop       (pop),
    .replace   (replace),
    .incr      (incr),
    .in_first  (dec_takenbr_target),
    .in_last   (last_pc),
    .count     (depth),
    .top_first (top_first),
    .top_last  (top_last),
    .nxt_count (nxt_count),
    .nxt_first (nxt_first),
    .nxt_last  (nxt_last),
    .nxt_cnt   (nxt_cnt)
  );

  // Qualification looks at the top entry as it will be after this cycle's update.
  assign thr_eff = (cfg_thresh == '0) ? CNT_W'(1) : cfg_thresh;
  assign body_ok = (MAX_BODY == 0) || ((nxt_last - nxt_first) <= BODY_LIM);
  assign qual    = (nxt_count != '0) && (nxt_cnt >= thr_eff) && body_ok;

  always_comb begin
    nxt_state = TRAIN;
    if (nxt_count == '0) nxt_state = IDLE;
    else if (qual)       nxt_state = LOCKED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      lock_cache <= 1'b0;
      lock_start <= 1'b0;
      lock_end   <= 1'b0;
    end else begin
      state      <= nxt_state;
      lock_cache <= (nxt_state == LOCKED);
      lock_start <= (nxt_state == LOCKED) && (state != LOCKED);
      lock_end   <= (nxt_state != LOCKED) && (state == LOCKED);
    end
  end

endmodule

// File: tb/tb_loop_lock_ctrl.sv
// Directed plus randomized checks of loop_lock_ctrl against a queue-based loop model.
module tb_loop_lock_ctrl;

  localparam int unsigned ENTRIES  = 4;
  localparam int unsigned PC_W     = 31;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned MAX_BODY = 32;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             inst_valid = 1'b0;
  logic             is_call = 1'b0;
  logic             flush = 1'b0;
  logic             dec_takenbr = 1'b0;
  logic [PC_W-1:0]  dec_takenbr_target = '0;
  logic [PC_W-1:0]  last_pc = '0;
  logic [CNT_W-1:0] cfg_thresh = 4'd3;
  logic             lock_cache, lock_start, lock_end;
  logic [2:0]       depth;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  loop_lock_ctrl #(
    .ENTRIES  (ENTRIES),
    .PC_W     (PC_W),
    .CNT_W    (CNT_W),
    .MAX_BODY (MAX_BODY)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .inst_valid         (inst_valid),
    .is_call            (is_call),
    .flush              (flush),
    .dec_takenbr        (dec_takenbr),
    .dec_takenbr_target (dec_takenbr_target),
    .last_pc            (last_pc),
    .cfg_thresh         (cfg_thresh),
    .lock_cache         (lock_cache),
    .lock_start         (lock_start),
    .lock_end           (lock_end),
    .depth              (depth)
  );

  always #5 clk = ~clk;

  // Reference model: the loop stack as a queue, innermost loop at the back.
  typedef struct {
    int unsigned first;
    int unsigned last;
    int unsigned cnt;
  } ent_t;

  ent_t        stk[$];
  bit          m_lock  = 1'b0;
  bit          m_start = 1'b0;
  bit          m_end   = 1'b0;

  task automatic model_step(bit r, bit iv, bit c, bit f, bit tb,
                            int unsigned tgt, int unsigned pc, int unsigned thr);
    bit          bwd, have, hit, leave, lk;
    int unsigned n, thr_e;
    if (r) begin
      stk.delete();
      m_lock = 0; m_start = 0; m_end = 0;
      return;
    end
    if (c || f) begin
      stk.delete();
    end else begin
      bwd   = tb && (tgt < pc);
      have  = stk.size() > 0;
      hit   = bwd && have && stk[$].first == tgt && stk[$].last == pc;
      leave = iv && have && !hit && (pc < stk[$].first || pc > stk[$].last);
      if (hit) begin
        n = stk.size();
        if (stk[n-1].cnt < CNT_MAX) stk[n-1].cnt = stk[n-1].cnt + 1;
      end else if (bwd) begin
        if (leave) void'(stk.pop_back());
        stk.push_back('{first: tgt, last: pc, cnt: 1});
        if (stk.size() > ENTRIES) void'(stk.pop_front());
      end else if (leave) begin
        void'(stk.pop_back());
      end
    end
    thr_e = (thr == 0) ? 1 : thr;
    lk = stk.size() > 0 && stk[$].cnt >= thr_e &&
         (MAX_BODY == 0 || stk[$].last - stk[$].first <= MAX_BODY);
    m_start = lk && !m_lock;
    m_end   = !lk && m_lock;
    m_lock  = lk;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(bit r, bit iv, bit c, bit f, bit tb,
                      int unsigned tgt, int unsigned pc, int unsigned thr);
    rst = r; inst_valid = iv; is_call = c; flush = f; dec_takenbr = tb;
    dec_takenbr_target = PC_W'(tgt); last_pc = PC_W'(pc); cfg_thresh = CNT_W'(thr);
    model_step(r, iv, c, f, tb, tgt, pc, thr);
    @(posedge clk);
    #1;
    chk("depth",      32'(depth),      32'(stk.size()));
    chk("lock_cache", 32'(lock_cache), 32'(m_lock));
    chk("lock_start", 32'(lock_start), 32'(m_start));
    chk("lock_end",   32'(lock_end),   32'(m_end));
  endtask

  // Idle in-range instruction: no branch, no exit.
  task automatic nop(int unsigned pc, int unsigned thr);
    step(0, 1, 0, 0, 0, 0, pc, thr);
  endtask

  initial begin
    int unsigned tgt, pc;

    step(1, 0, 0, 0, 0, 0, 0, 3);
    step(1, 0, 0, 0, 0, 0, 0, 3);
    chk("reset_depth", 32'(depth), 0);
    chk("reset_lock", 32'(lock_cache), 0);

    // Lock on threshold
    step(0, 1, 0, 0, 1, 'h100, 'h120, 3);
    chk("thr_first_nolock", 32'(lock_cache), 0);
    step(0, 1, 0, 0, 1, 'h100, 'h120, 3);
    step(0, 1, 0, 0, 1, 'h100, 'h120, 3);
    chk("thr_lock_start", 32'(lock_start), 1);
    nop('h110, 3);
    chk("thr_lock_held", 32'(lock_cache), 1);
    chk("thr_start_once", 32'(lock_start), 0);
    chk("thr_depth", 32'(depth), 1);
    step(0, 1, 0, 1, 0, 0, 'h110, 3);
    chk("flush_end", 32'(lock_end), 1);

    // Nested exit
    step(0, 1, 0, 0, 1, 'h100, 'h180, 3);
    repeat (3) step(0, 1, 0, 0, 1, 'h120, 'h140, 3);
    chk("nest_locked", 32'(lock_cache), 1);
    chk("nest_depth2", 32'(depth), 2);
    nop('h150, 3);
    chk("nest_pop_end", 32'(lock_end), 1);
    chk("nest_pop_depth", 32'(depth), 1);
    chk("nest_pop_train", 32'(lock_cache), 0);

    // Clear with simultaneous backward branch while locked
    repeat (3) step(0, 1, 0, 0, 1, 'h120, 'h140, 3);
    chk("clr_pre_lock", 32'(lock_cache), 1);
    step(0, 1, 1, 0, 1, 'h100, 'h160, 3);
    chk("clr_depth", 32'(depth), 0);
    chk("clr_lock", 32'(lock_cache), 0);
    chk("clr_end", 32'(lock_end), 1);

    // Hold when inst_valid is low
    repeat (3) step(0, 1, 0, 0, 1, 'h100, 'h120, 3);
    step(0, 0, 0, 0, 0, 0, 'h400, 3);
    chk("hold_lock", 32'(lock_cache), 1);
    chk("hold_depth", 32'(depth), 1);

    // Overflow and drain
    step(0, 1, 0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 1, 'h100 + 'h10 * i, 'h200 - 'h10 * i, 3);
    chk("ovf_depth", 32'(depth), 4);
    for (int i = 0; i < 5; i++) nop('h400, 3);
    chk("drain_depth", 32'(depth), 0);

    // Size limit and saturation
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 1, 'h100, 'h140, 3);
    chk("big_body_nolock", 32'(lock_cache), 0);
    nop('h120, 1);
    chk("big_body_thr1", 32'(lock_cache), 0);

    // Threshold lowering and zero threshold
    step(0, 1, 0, 1, 0, 0, 0, 15);
    repeat (3) step(0, 1, 0, 0, 1, 'h100, 'h120, 15);
    chk("thr15_train", 32'(lock_cache), 0);
    nop('h110, 2);
    chk("thr_lowered", 32'(lock_start), 1);
    step(0, 1, 0, 0, 1, 'h108, 'h118, 0);
    chk("thr0_lock", 32'(lock_cache), 1);

    // Reset while locked
    step(1, 0, 0, 0, 0, 0, 0, 3);
    chk("rst_lock", 32'(lock_cache), 0);
    chk("rst_no_end", 32'(lock_end), 0);
    chk("rst_depth", 32'(depth), 0);

    // Random
    for (int i = 0; i < 600; i++) begin
      tgt = 'h100 + 'h8 * $urandom_range(0, 12);
      pc  = 'h100 + 'h8 * $urandom_range(0, 12);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 1) == 1), tgt, pc, $urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
